// File: rtl/min_max_pkg.sv
// Shared types for the min_max LED bar display and its decoder.
// Command encoding, decoder FSM states and bar-width helper.
package min_max_pkg;

  typedef enum logic [1:0] {
    COM_NORMAL = 2'b00,
    COM_LINEAR = 2'b01,
    COM_OFF    = 2'b10,
    COM_ON     = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN,
    ST_DONE
  } state_t;

  function automatic int bar_width(input int valsize);
    return 2 ** valsize;
  endfunction

endpackage

// File: rtl/min_max_decoder_if.sv
// Decoded-result handshake bundle of the min_max decoder.
// master: producer (valid + result out, ready in); slave: consumer.
interface min_max_decoder_if #(
  parameter int VALSIZE = 4
);
  import min_max_pkg::*;

  logic               valid;
  logic               ready;
  mode_t              mode;
  logic [VALSIZE-1:0] min;
  logic [VALSIZE-1:0] value;
  logic [VALSIZE-1:0] max;
  logic               osc_seen;
  logic               error;

  modport master (
    output valid, mode, min, value, max,
    output osc_seen, error,
    input  ready
  );

  modport slave (
    input  valid, mode, min, value, max,
    input  osc_seen, error,
    output ready
  );

endinterface

// File: rtl/min_max_decoder_led_run_tracker.sv
// Serial run tracker: lowest/highest set index and count of 0->1 runs.
// Ports: clk/rst, clear, en, bit_i at idx_i; low/high/runs/any out.
module led_run_tracker #(
  parameter int VALSIZE = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic               bit_i,
  input  logic [VALSIZE-1:0] idx_i,
  output logic [VALSIZE-1:0] low_o,
  output logic [VALSIZE-1:0] high_o,
  output logic [VALSIZE-1:0] runs_o,
  output logic               any_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q <= 1'b0;
      low_o  <= '0;
      high_o <= '0;
      runs_o <= '0;
      any_o  <= 1'b0;
    end else if (clear_i) begin
      prev_q <= 1'b0;
      low_o  <= '0;
      high_o <= '0;
      runs_o <= '0;
      any_o  <= 1'b0;
    end else if (en_i) begin
      prev_q <= bit_i;
      if (bit_i) begin
        if (!any_o) low_o <= idx_i;
        high_o <= idx_i;
        any_o  <= 1'b1;
        // index 0 always opens a run
        if (idx_i == '0 || !prev_q)
          runs_o <= runs_o + VALSIZE'(1);
      end
    end
  end

endmodule

// File: rtl/min_max_decoder.sv
// Recovers command/min/value/max from an observed min_max LED bar.
// Ports: clk_i, rst_n_i, start_i, leds_i, osc_i; result on res (master).
module min_max_decoder
  import min_max_pkg::*;
#(
  parameter int VALSIZE = 4,
  parameter int TIMEOUT = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic [bar_width(VALSIZE)-1:0] leds_i,
  input  logic          osc_i,
  min_max_decoder_if.master res
);

  localparam int N  = bar_width(VALSIZE);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t state_q, state_d;

  logic [N-1:0]       a_q, b_q;
  logic               osc_ref_q;
  logic               seen_q;
  logic [TW-1:0]      timer_q;
  logic [VALSIZE-1:0] idx_q;

  logic               valid_q;
  mode_t              mode_q;
  logic [VALSIZE-1:0] min_q, value_q, max_q;
  logic               osc_seen_q, error_q;

  logic osc_tog, timeout, last;
  logic clear, scan_en;

  assign osc_tog = osc_i != osc_ref_q;
  assign timeout = timer_q == TW'(TIMEOUT - 1);
  assign last    = idx_q == VALSIZE'(N - 1);
  assign clear   = state_q == ST_IDLE && start_i;
  assign scan_en = state_q == ST_SCAN;

  logic [VALSIZE-1:0] s_low, s_high, s_runs;
  logic [VALSIZE-1:0] o_low, o_high, o_runs;
  logic               s_any, o_any;

  led_run_tracker #(.VALSIZE(VALSIZE)) u_s (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (clear),
    .en_i    (scan_en),
    .bit_i   (a_q[idx_q] & b_q[idx_q]),
    .idx_i   (idx_q),
    .low_o   (s_low),
    .high_o  (s_high),
    .runs_o  (s_runs),
    .any_o   (s_any)
  );

  led_run_tracker #(.VALSIZE(VALSIZE)) u_o (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (clear),
    .en_i    (scan_en),
    .bit_i   (a_q[idx_q] | b_q[idx_q]),
    .idx_i   (idx_q),
    .low_o   (o_low),
    .high_o  (o_high),
    .runs_o  (o_runs),
    .any_o   (o_any)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_WAIT;
      ST_WAIT: if (osc_tog || timeout) state_d = ST_SCAN;
      ST_SCAN: if (last) state_d = ST_DONE;
      ST_DONE: if (valid_q && res.ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  mode_t              dec_mode;
  logic [VALSIZE-1:0] dec_min, dec_value, dec_max;
  logic               dec_err;
  logic               all_on, bad;

  // all-on: S is one run covering every index
  assign all_on = s_any && s_runs == VALSIZE'(1) &&
                  s_low == '0 && s_high == VALSIZE'(N - 1);
  assign bad = !s_any || s_runs > VALSIZE'(1) ||
               o_runs > VALSIZE'(1) || o_low != s_low;

  always_comb begin
    dec_mode  = COM_OFF;
    dec_min   = '0;
    dec_value = '0;
    dec_max   = '0;
    dec_err   = 1'b0;
    if (!o_any) begin
      dec_mode = COM_OFF;
    end else if (all_on) begin
      dec_mode  = COM_ON;
      dec_value = VALSIZE'(N - 1);
      dec_max   = VALSIZE'(N - 1);
    end else if (bad) begin
      dec_err = 1'b1;
    end else if (a_q == b_q && s_low == '0) begin
      dec_mode  = COM_LINEAR;
      dec_value = s_high;
      dec_max   = s_high;
    end else begin
      dec_mode  = COM_NORMAL;
      dec_min   = s_low;
      dec_value = s_high;
      dec_max   = o_high;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q        <= '0;
      b_q        <= '0;
      osc_ref_q  <= 1'b0;
      seen_q     <= 1'b0;
      timer_q    <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      mode_q     <= COM_NORMAL;
      min_q      <= '0;
      value_q    <= '0;
      max_q      <= '0;
      osc_seen_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            a_q       <= leds_i;
            osc_ref_q <= osc_i;
            timer_q   <= '0;
          end
        end
        ST_WAIT: begin
          if (osc_tog) begin
            b_q    <= leds_i;
            seen_q <= 1'b1;
          end else if (timeout) begin
            b_q    <= a_q;
            seen_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_SCAN: begin
          idx_q <= last ? '0 : idx_q + VALSIZE'(1);
        end
        ST_DONE: begin
          // first DONE cycle latches the result
          if (!valid_q) begin
            valid_q    <= 1'b1;
            mode_q     <= dec_mode;
            min_q      <= dec_min;
            value_q    <= dec_value;
            max_q      <= dec_max;
            osc_seen_q <= seen_q;
            error_q    <= dec_err;
          end else if (res.ready) begin
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign res.valid    = valid_q;
  assign res.mode     = mode_q;
  assign res.min      = min_q;
  assign res.value    = value_q;
  assign res.max      = max_q;
  assign res.osc_seen = osc_seen_q;
  assign res.error    = error_q;

endmodule

// File: tb/tb_min_max_decoder.sv
// Directed bench for min_max_decoder (VALSIZE=4, TIMEOUT=8).
// Checks latency, decoded fields, handshake hold, reset.
module tb_min_max_decoder;
  import min_max_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] leds = '0;
  logic        osc = 1'b0;

  int checks = 0;
  int failures = 0;
  int lat;
  int nval;

  min_max_decoder_if #(.VALSIZE(4)) res_if ();

  min_max_decoder #(.VALSIZE(4), .TIMEOUT(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .leds_i  (leds),
    .osc_i   (osc),
    .res     (res_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int l, input int el,
                         input logic [1:0] m, input logic [3:0] mn,
                         input logic [3:0] v, input logic [3:0] mx,
                         input logic s, input logic e);
    chk({tag, ".lat"}, l, el);
    chk({tag, ".mode"}, res_if.mode, m);
    chk({tag, ".min"}, res_if.min, mn);
    chk({tag, ".value"}, res_if.value, v);
    chk({tag, ".max"}, res_if.max, mx);
    chk({tag, ".seen"}, res_if.osc_seen, s);
    chk({tag, ".err"}, res_if.error, e);
  endtask

  task automatic run(input logic [15:0] a, input logic osc0,
                     input logic tog, input logic [15:0] b,
                     input int poke, output int l);
    @(negedge clk);
    leds = a;
    osc = osc0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (tog) begin
      osc = ~osc0;
      leds = b;
    end
    l = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      start = (k == poke);
      if (res_if.valid === 1'b1) begin
        l = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic accept(input string tag);
    res_if.ready = 1'b1;
    @(posedge clk);
    #1;
    res_if.ready = 1'b0;
    chk({tag, ".acc"}, res_if.valid, 1'b0);
  endtask

  task automatic idle_watch(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (res_if.valid !== 1'b0) cnt++;
    end
  endtask

  initial begin
    res_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", res_if.valid, 1'b0);
    chk("rst.mode", res_if.mode, 2'b00);
    chk("rst.value", res_if.value, 4'd0);
    chk("rst.err", res_if.error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run(16'h01F8, 1'b0, 1'b1, 16'h1FF8, 0, lat);
    chk_res("normal", lat, 18, 2'b00, 4'd3, 4'd8, 4'd12, 1'b1, 1'b0);
    accept("normal");

    run(16'h003F, 1'b0, 1'b0, 16'h0000, 0, lat);
    chk_res("linear", lat, 25, 2'b01, 4'd0, 4'd5, 4'd5, 1'b0, 1'b0);
    accept("linear");

    run(16'hFFFF, 1'b1, 1'b0, 16'h0000, 0, lat);
    chk_res("allon", lat, 25, 2'b11, 4'd0, 4'd15, 4'd15, 1'b0, 1'b0);
    accept("allon");

    run(16'h0000, 1'b0, 1'b0, 16'h0000, 0, lat);
    chk_res("alloff", lat, 25, 2'b10, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    accept("alloff");

    run(16'h00C6, 1'b0, 1'b0, 16'h0000, 0, lat);
    chk_res("tworun", lat, 25, 2'b10, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    accept("tworun");

    run(16'h0010, 1'b1, 1'b1, 16'h0030, 0, lat);
    chk_res("narrow", lat, 18, 2'b00, 4'd4, 4'd4, 4'd5, 1'b1, 1'b0);
    accept("narrow");

    // start pulsed mid-SCAN, then held during DONE with ready low
    run(16'h003F, 1'b0, 1'b0, 16'h0000, 12, lat);
    chk_res("hs", lat, 25, 2'b01, 4'd0, 4'd5, 4'd5, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("hs.hold.valid", res_if.valid, 1'b1);
      chk("hs.hold.mode", res_if.mode, 2'b01);
      chk("hs.hold.value", res_if.value, 4'd5);
      chk("hs.hold.max", res_if.max, 4'd5);
    end
    start = 1'b0;
    accept("hs");
    chk("hs.outs_kept", res_if.value, 4'd5);
    idle_watch(30, nval);
    chk("hs.no_queue", nval, 0);

    run(16'h01F8, 1'b0, 1'b1, 16'h1FF8, 0, lat);
    chk_res("hs.next", lat, 18, 2'b00, 4'd3, 4'd8, 4'd12, 1'b1, 1'b0);
    accept("hs.next");

    // reset while scanning a fresh decode
    @(negedge clk);
    leds = 16'h0010;
    osc = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    osc = 1'b1;
    leds = 16'h0030;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.valid", res_if.valid, 1'b0);
    chk("mrst.mode", res_if.mode, 2'b00);
    chk("mrst.min", res_if.min, 4'd0);
    chk("mrst.value", res_if.value, 4'd0);
    chk("mrst.max", res_if.max, 4'd0);
    chk("mrst.seen", res_if.osc_seen, 1'b0);
    chk("mrst.err", res_if.error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_watch(30, nval);
    chk("mrst.idle", nval, 0);

    run(16'h01F8, 1'b0, 1'b1, 16'h1FF8, 0, lat);
    chk_res("post", lat, 18, 2'b00, 4'd3, 4'd8, 4'd12, 1'b1, 1'b0);
    accept("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
